// File: rtl/jtdsp16_do_cache_if.sv
// Bus between the DSP16 decoder/ROM side and the do/redo loop cache.
//
// Handshake: the cache never back-pressures. A word moves across this bus
// on any clk edge where cen=1 and fetch_adv=1: in FILL the cache captures
// rom_dout, in PLAY it steps past the word currently on cache_dout.
// Without fetch_adv the cache holds its position and its output.
// do_start is a one-cen command pulse and is accepted only while busy=0.
interface jtdsp16_do_cache_if;
    logic        cen;
    logic        do_start;
    logic [10:0] do_data;
    logic        fetch_adv;
    logic [15:0] rom_dout;
    logic [15:0] cache_dout;
    logic        cache_sel;
    logic        pc_hold;
    logic        busy;
    logic [6:0]  iter_left;
    logic [1:0]  state;      // FSM state, debug visibility only

    modport master (
        output cen, do_start, do_data, fetch_adv, rom_dout,
        input  cache_dout, cache_sel, pc_hold, busy, iter_left, state
    );

    modport slave (
        input  cen, do_start, do_data, fetch_adv, rom_dout,
        output cache_dout, cache_sel, pc_hold, busy, iter_left, state
    );
endinterface

// File: rtl/jtdsp16_do_cache.sv
// Loop cache for the DSP16 "do K {N instr}" and "redo K" instructions.
// The first pass of a loop runs from ROM while the words are captured;
// the remaining passes are replayed from the local buffer with the PC held.
module jtdsp16_do_cache #(
    parameter int DEPTH = 15,
    parameter int AW    = 4
) (
    input logic               clk,
    input logic               rst,
    jtdsp16_do_cache_if.slave bus
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_FILL = 2'd1;
    localparam logic [1:0] ST_PLAY = 2'd2;

    logic [1:0]    state;
    logic [AW-1:0] idx;
    logic [AW-1:0] n_len;
    logic [6:0]    kreq;
    logic [6:0]    iter_left;
    logic [15:0]   mem [0:DEPTH-1];

    logic [AW-1:0] cmd_n;
    logic [6:0]    cmd_k;
    logic          last_word;

    assign cmd_n     = AW'(bus.do_data[10:7]);
    assign cmd_k     = bus.do_data[6:0];
    // n_len is never zero outside IDLE, so n_len-1 is a valid last index
    assign last_word = (idx == n_len - AW'(1));

    // Loop buffer: written only during the first (ROM) pass, never reset
    always_ff @(posedge clk) begin
        if (bus.cen && state == ST_FILL && bus.fetch_adv)
            mem[idx] <= bus.rom_dout;
    end

    // Control FSM: command decode, capture indexing and replay counting
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            idx       <= '0;
            n_len     <= '0;
            kreq      <= '0;
            iter_left <= '0;
        end else if (bus.cen) begin
            case (state)
                ST_IDLE: begin
                    if (bus.do_start) begin
                        if (cmd_n != '0) begin
                            n_len <= cmd_n;
                            kreq  <= cmd_k;
                            idx   <= '0;
                            state <= ST_FILL;
                        end else if (n_len != '0 && cmd_k != 7'd0) begin
                            // redo: replay the buffered body K more times
                            iter_left <= cmd_k;
                            idx       <= '0;
                            state     <= ST_PLAY;
                        end
                    end
                end
                ST_FILL: begin
                    if (bus.fetch_adv) begin
                        if (last_word) begin
                            idx <= '0;
                            // the ROM pass counts as one iteration; K=0 acts as K=1
                            if (kreq >= 7'd2) begin
                                iter_left <= kreq - 7'd1;
                                state     <= ST_PLAY;
                            end else begin
                                state <= ST_IDLE;
                            end
                        end else begin
                            idx <= idx + AW'(1);
                        end
                    end
                end
                ST_PLAY: begin
                    if (bus.fetch_adv) begin
                        if (last_word) begin
                            idx       <= '0;
                            iter_left <= iter_left - 7'd1;
                            // leaving on this edge hands the next fetch back to ROM
                            if (iter_left == 7'd1)
                                state <= ST_IDLE;
                        end else begin
                            idx <= idx + AW'(1);
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    idx   <= '0;
                end
            endcase
        end
    end

    assign bus.busy       = (state != ST_IDLE);
    assign bus.cache_sel  = (state == ST_PLAY);
    assign bus.pc_hold    = (state == ST_PLAY);
    assign bus.cache_dout = (state == ST_PLAY) ? mem[idx] : 16'd0;
    assign bus.iter_left  = iter_left;
    assign bus.state      = state;

endmodule
